// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account store: session states, default widths
// and the factory account table (PINs and opening balances).
package atm_pkg;

  localparam int BALANCE_WIDTH_DEF = 20;
  localparam int PIN_WIDTH_DEF     = 16;
  localparam int MAX_ACCOUNTS      = 8;
  localparam int TRY_CNT_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_WAIT_PIN = 3'd2,
    ST_CHECK    = 3'd3,
    ST_AUTH     = 3'd4
  } acct_state_e;

  localparam logic [PIN_WIDTH_DEF-1:0] INIT_PIN [MAX_ACCOUNTS] = '{
    16'h1111, 16'h2222, 16'h2468, 16'h3333,
    16'h4444, 16'h5555, 16'h6666, 16'h7777
  };

  localparam logic [BALANCE_WIDTH_DEF-1:0] INIT_BALANCE [MAX_ACCOUNTS] = '{
    20'd1000,  20'd2500, 20'd5000, 20'd750,
    20'd12000, 20'd300,  20'd0,    20'd999999
  };

endpackage

// File: rtl/pin_try_counter.sv
// Saturating count of consecutive wrong PINs for the account in session.
module pin_try_counter
  import atm_pkg::*;
#(
  parameter int MAX_TRIES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_reached_o,
  output logic last_try_o
);

  logic [TRY_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < TRY_CNT_W'(MAX_TRIES))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_reached_o = (cnt_q >= TRY_CNT_W'(MAX_TRIES));
  // One more miss from here locks the account.
  assign last_try_o      = (cnt_q == TRY_CNT_W'(MAX_TRIES - 1));

endmodule

// File: rtl/atm_account_store.sv
// Account table and PIN authentication in front of the ATM control FSM.
// All inputs are one-cycle pulses except card_out (level); all outputs are registered.
module atm_account_store
  import atm_pkg::*;
#(
  parameter int balance_width = BALANCE_WIDTH_DEF,
  parameter int NUM_ACCOUNTS  = 8,
  parameter int ID_WIDTH      = 3,
  parameter int PIN_WIDTH     = PIN_WIDTH_DEF,
  parameter int MAX_TRIES     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic [ID_WIDTH-1:0]      card_id,
  input  logic                     pin_valid,
  input  logic [PIN_WIDTH-1:0]     pin,
  input  logic                     commit,
  input  logic [balance_width-1:0] balance_in,
  input  logic                     card_out,
  output logic [balance_width-1:0] current_balance,
  output logic                     wrong_psw,
  output logic                     pin_ok,
  output logic                     invalid_card,
  output logic                     locked,
  output logic                     session_active,
  output acct_state_e              state_dbg_o
);

  acct_state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [PIN_WIDTH-1:0]      pin_q, pin_d;
  logic [balance_width-1:0]  cur_bal_q, cur_bal_d;
  logic                      pin_ok_q, pin_ok_d;
  logic                      wrong_q, wrong_d;
  logic                      inv_q, inv_d;
  logic                      locked_q, locked_d;
  logic                      session_q, session_d;

  logic [balance_width-1:0]  bal_q [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0]   lock_q;

  logic                      bal_we, lock_set;
  logic                      try_clr, try_inc;
  logic                      try_limit, try_last;
  logic                      id_ok;
  logic [PIN_WIDTH-1:0]      exp_pin;

  assign id_ok   = (32'(id_q) < NUM_ACCOUNTS);
  assign exp_pin = PIN_WIDTH'(INIT_PIN[id_q]);

  pin_try_counter #(.MAX_TRIES(MAX_TRIES)) u_tries (
    .clk             (clk),
    .rst             (rst),
    .clr_i           (try_clr),
    .inc_i           (try_inc),
    .limit_reached_o (try_limit),
    .last_try_o      (try_last)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    pin_d     = pin_q;
    cur_bal_d = cur_bal_q;
    pin_ok_d  = pin_ok_q;
    wrong_d   = 1'b0;
    inv_d     = 1'b0;
    locked_d  = 1'b0;
    bal_we    = 1'b0;
    lock_set  = 1'b0;
    try_clr   = 1'b0;
    try_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (card_in) begin
          id_d    = card_id;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (!id_ok || lock_q[id_q]) begin
          inv_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cur_bal_d = bal_q[id_q];
          try_clr   = 1'b1;
          state_d   = ST_WAIT_PIN;
        end
      end
      ST_WAIT_PIN: begin
        if (pin_valid) begin
          pin_d   = pin;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (pin_q == exp_pin) begin
          pin_ok_d = 1'b1;
          try_clr  = 1'b1;
          state_d  = ST_AUTH;
        end else begin
          wrong_d = 1'b1;
          try_inc = 1'b1;
          if (try_last || try_limit) begin
            lock_set  = 1'b1;
            locked_d  = 1'b1;
            cur_bal_d = '0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WAIT_PIN;
          end
        end
      end
      ST_AUTH: begin
        if (commit) begin
          bal_we    = 1'b1;
          cur_bal_d = balance_in;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Eject wins over everything except a commit landing in the same cycle.
    if (card_out && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      pin_ok_d  = 1'b0;
      cur_bal_d = '0;
      wrong_d   = 1'b0;
      inv_d     = 1'b0;
      locked_d  = 1'b0;
      lock_set  = 1'b0;
      try_inc   = 1'b0;
    end

    session_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      pin_q     <= '0;
      cur_bal_q <= '0;
      pin_ok_q  <= 1'b0;
      wrong_q   <= 1'b0;
      inv_q     <= 1'b0;
      locked_q  <= 1'b0;
      session_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pin_q     <= pin_d;
      cur_bal_q <= cur_bal_d;
      pin_ok_q  <= pin_ok_d;
      wrong_q   <= wrong_d;
      inv_q     <= inv_d;
      locked_q  <= locked_d;
      session_q <= session_d;
    end
  end

  // Reset is a power-on event: committed balances revert, locks clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_q[i] <= balance_width'(INIT_BALANCE[i]);
      end
      lock_q <= '0;
    end else begin
      if (bal_we) begin
        bal_q[id_q] <= balance_in;
      end
      if (lock_set) begin
        lock_q[id_q] <= 1'b1;
      end
    end
  end

  assign current_balance = cur_bal_q;
  assign wrong_psw       = wrong_q;
  assign pin_ok          = pin_ok_q;
  assign invalid_card    = inv_q;
  assign locked          = locked_q;
  assign session_active  = session_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_atm_account_store.sv
// Directed bench for atm_account_store built with six accounts so ids 6 and 7 are out of range.
module tb_atm_account_store;
  import atm_pkg::*;

  localparam int BW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          card_in = 1'b0;
  logic [2:0]    card_id = '0;
  logic          pin_valid = 1'b0;
  logic [15:0]   pin = '0;
  logic          commit = 1'b0;
  logic [BW-1:0] balance_in = '0;
  logic          card_out = 1'b0;
  logic [BW-1:0] current_balance;
  logic          wrong_psw, pin_ok, invalid_card, locked, session_active;
  acct_state_e   state_dbg;

  int n_vec = 0;
  int n_err = 0;

  atm_account_store #(
    .balance_width(BW), .NUM_ACCOUNTS(6), .ID_WIDTH(3), .PIN_WIDTH(16), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_id(card_id),
    .pin_valid(pin_valid), .pin(pin), .commit(commit), .balance_in(balance_in),
    .card_out(card_out), .current_balance(current_balance), .wrong_psw(wrong_psw),
    .pin_ok(pin_ok), .invalid_card(invalid_card), .locked(locked),
    .session_active(session_active), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic insert(input logic [2:0] id);
    card_in = 1'b1; card_id = id;
    tick();
    card_in = 1'b0;
    tick();
  endtask

  task automatic enter_pin(input logic [15:0] p);
    pin_valid = 1'b1; pin = p;
    tick();
    pin_valid = 1'b0;
    tick();
  endtask

  task automatic eject();
    card_out = 1'b1;
    tick();
    card_out = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_vec++; if (current_balance !== '0) begin n_err++; $display("FAIL reset_balance got %0d want 0", current_balance); end
    n_vec++; if ({wrong_psw, pin_ok, invalid_card, locked, session_active} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 00000", {wrong_psw, pin_ok, invalid_card, locked, session_active}); end
    n_vec++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_auth();
    card_in = 1'b1; card_id = 3'd2;
    tick();
    card_in = 1'b0;
    n_vec++; if (state_dbg !== ST_SELECT || session_active !== 1'b1) begin
      n_err++; $display("FAIL sel_state got st=%0d sess=%b want st=%0d sess=1", state_dbg, session_active, ST_SELECT); end
    tick();
    n_vec++; if (current_balance !== 20'd5000) begin n_err++; $display("FAIL id2_balance got %0d want 5000", current_balance); end
    n_vec++; if (state_dbg !== ST_WAIT_PIN || invalid_card !== 1'b0) begin
      n_err++; $display("FAIL id2_wait got st=%0d inv=%b want st=%0d inv=0", state_dbg, invalid_card, ST_WAIT_PIN); end
    pin_valid = 1'b1; pin = 16'h2468;
    tick();
    pin_valid = 1'b0;
    n_vec++; if (pin_ok !== 1'b0 || state_dbg !== ST_CHECK) begin
      n_err++; $display("FAIL check_cycle got ok=%b st=%0d want ok=0 st=%0d", pin_ok, state_dbg, ST_CHECK); end
    tick();
    n_vec++; if (pin_ok !== 1'b1 || wrong_psw !== 1'b0 || state_dbg !== ST_AUTH) begin
      n_err++; $display("FAIL id2_auth got ok=%b wrong=%b st=%0d want ok=1 wrong=0 st=%0d", pin_ok, wrong_psw, state_dbg, ST_AUTH); end
  endtask

  task automatic test_commit();
    commit = 1'b1; balance_in = 20'd4200;
    tick();
    commit = 1'b0;
    n_vec++; if (current_balance !== 20'd4200) begin n_err++; $display("FAIL commit_cur got %0d want 4200", current_balance); end
    eject();
    n_vec++; if (state_dbg !== ST_IDLE || pin_ok !== 1'b0 || current_balance !== '0 || session_active !== 1'b0) begin
      n_err++; $display("FAIL eject got st=%0d ok=%b bal=%0d sess=%b want idle/0/0/0", state_dbg, pin_ok, current_balance, session_active); end
    insert(3'd2);
    n_vec++; if (current_balance !== 20'd4200) begin n_err++; $display("FAIL reinsert_bal got %0d want 4200", current_balance); end
    // Commit while still waiting for a PIN must not touch the table.
    commit = 1'b1; balance_in = 20'd7;
    tick();
    commit = 1'b0;
    n_vec++; if (current_balance !== 20'd4200) begin n_err++; $display("FAIL wait_commit_cur got %0d want 4200", current_balance); end
    eject();
    insert(3'd2);
    n_vec++; if (current_balance !== 20'd4200) begin n_err++; $display("FAIL wait_commit_tbl got %0d want 4200", current_balance); end
    eject();
    tick();
  endtask

  task automatic test_lockout();
    logic [15:0] bad_pins [3];
    bad_pins[0] = 16'h0000; bad_pins[1] = 16'h5554; bad_pins[2] = 16'hFFFF;
    insert(3'd5);
    n_vec++; if (current_balance !== 20'd300) begin n_err++; $display("FAIL id5_balance got %0d want 300", current_balance); end
    for (int i = 0; i < 3; i++) begin
      enter_pin(bad_pins[i]);
      n_vec++; if (wrong_psw !== 1'b1 || pin_ok !== 1'b0) begin
        n_err++; $display("FAIL wrong_%0d got wrong=%b ok=%b want 1/0", i, wrong_psw, pin_ok); end
      n_vec++; if (locked !== (i == 2)) begin n_err++; $display("FAIL locked_%0d got %b want %b", i, locked, (i == 2)); end
      n_vec++; if (state_dbg !== ((i == 2) ? ST_IDLE : ST_WAIT_PIN)) begin
        n_err++; $display("FAIL lock_state_%0d got %0d", i, state_dbg); end
    end
    tick();
    n_vec++; if (wrong_psw !== 1'b0 || locked !== 1'b0 || session_active !== 1'b0) begin
      n_err++; $display("FAIL lock_pulse got wrong=%b locked=%b sess=%b want 000", wrong_psw, locked, session_active); end
    insert(3'd5);
    n_vec++; if (invalid_card !== 1'b1 || state_dbg !== ST_IDLE) begin
      n_err++; $display("FAIL locked_reinsert got inv=%b st=%0d want 1/%0d", invalid_card, state_dbg, ST_IDLE); end
    enter_pin(16'h5555);
    n_vec++; if (pin_ok !== 1'b0 || wrong_psw !== 1'b0 || invalid_card !== 1'b0 || current_balance !== '0) begin
      n_err++; $display("FAIL locked_pin got ok=%b wrong=%b inv=%b bal=%0d want 0/0/0/0", pin_ok, wrong_psw, invalid_card, current_balance); end
  endtask

  task automatic test_invalid_id();
    logic [2:0] bad_ids [2];
    bad_ids[0] = 3'd7; bad_ids[1] = 3'd6;
    for (int i = 0; i < 2; i++) begin
      insert(bad_ids[i]);
      n_vec++; if (invalid_card !== 1'b1 || state_dbg !== ST_IDLE || current_balance !== '0) begin
        n_err++; $display("FAIL bad_id_%0d got inv=%b st=%0d bal=%0d want 1/idle/0", bad_ids[i], invalid_card, state_dbg, current_balance); end
      tick();
      n_vec++; if (invalid_card !== 1'b0) begin n_err++; $display("FAIL inv_pulse_%0d got %b want 0", bad_ids[i], invalid_card); end
    end
    insert(3'd0);
    n_vec++; if (invalid_card !== 1'b0 || current_balance !== 20'd1000) begin
      n_err++; $display("FAIL id0 got inv=%b bal=%0d want 0/1000", invalid_card, current_balance); end
    eject();
  endtask

  task automatic test_commit_eject();
    insert(3'd2);
    enter_pin(16'h2468);
    commit = 1'b1; card_out = 1'b1; balance_in = 20'd3100;
    tick();
    commit = 1'b0; card_out = 1'b0;
    n_vec++; if (state_dbg !== ST_IDLE || pin_ok !== 1'b0 || current_balance !== '0) begin
      n_err++; $display("FAIL commit_eject got st=%0d ok=%b bal=%0d want idle/0/0", state_dbg, pin_ok, current_balance); end
    insert(3'd2);
    n_vec++; if (current_balance !== 20'd3100) begin n_err++; $display("FAIL commit_eject_tbl got %0d want 3100", current_balance); end
  endtask

  task automatic test_back_to_back();
    enter_pin(16'h2468);
    commit = 1'b1; balance_in = 20'd100;
    tick();
    n_vec++; if (current_balance !== 20'd100) begin n_err++; $display("FAIL b2b_first got %0d want 100", current_balance); end
    balance_in = 20'd200;
    tick();
    commit = 1'b0;
    n_vec++; if (current_balance !== 20'd200) begin n_err++; $display("FAIL b2b_second got %0d want 200", current_balance); end
    card_in = 1'b1; card_id = 3'd0;
    tick();
    card_in = 1'b0;
    tick();
    n_vec++; if (state_dbg !== ST_AUTH || current_balance !== 20'd200 || pin_ok !== 1'b1) begin
      n_err++; $display("FAIL card_in_auth got st=%0d bal=%0d ok=%b want auth/200/1", state_dbg, current_balance, pin_ok); end
  endtask

  task automatic test_rst_mid_auth();
    rst = 1'b1;
    #1;
    n_vec++; if (current_balance !== '0 || pin_ok !== 1'b0 || session_active !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_err++; $display("FAIL async_rst got bal=%0d ok=%b sess=%b st=%0d want 0/0/0/idle", current_balance, pin_ok, session_active, state_dbg); end
    tick();
    rst = 1'b0;
    tick();
    insert(3'd2);
    n_vec++; if (current_balance !== 20'd5000) begin n_err++; $display("FAIL rst_revert got %0d want 5000", current_balance); end
    eject();
    insert(3'd5);
    n_vec++; if (invalid_card !== 1'b0 || current_balance !== 20'd300) begin
      n_err++; $display("FAIL rst_unlock got inv=%b bal=%0d want 0/300", invalid_card, current_balance); end
    enter_pin(16'h0001);
    enter_pin(16'h0002);
    enter_pin(16'h5555);
    n_vec++; if (pin_ok !== 1'b1 || locked !== 1'b0 || state_dbg !== ST_AUTH) begin
      n_err++; $display("FAIL tries_then_ok got ok=%b locked=%b st=%0d want 1/0/auth", pin_ok, locked, state_dbg); end
    eject();
    tick();
  endtask

  initial begin
    test_reset();
    test_auth();
    test_commit();
    test_lockout();
    test_invalid_id();
    test_commit_eject();
    test_back_to_back();
    test_rst_mid_auth();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/atm_account_store.md
# atm_account_store

Account storage and PIN authentication stage directly upstream of the ATM control FSM. It holds a small table of accounts, each with a PIN, a balance and a lock flag. It validates the inserted card and the entered PIN, and drives the `current_balance` and `wrong_psw` inputs of the FSM. When the FSM commits a transaction, the block writes the FSM's resulting `balance` back into the selected account.

## Interface
- `balance_width`, 20, balance word width (matches the FSM).
- `NUM_ACCOUNTS`, 8, number of stored accounts.
- `ID_WIDTH`, 3, card/account id width.
- `PIN_WIDTH`, 16, PIN width.
- `MAX_TRIES`, 3, wrong PINs allowed before the account locks.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `card_in` in 1: one-cycle pulse; a card with `card_id` has been inserted.
- `card_id` in ID_WIDTH: account index, sampled on `card_in`.
- `pin_valid` in 1: one-cycle pulse; `pin` holds an entered PIN.
- `pin` in PIN_WIDTH: entered PIN.
- `commit` in 1: one-cycle pulse; write `balance_in` to the active account.
- `balance_in` in balance_width: updated balance from the FSM.
- `card_out` in 1: FSM session end/eject (level).
- `current_balance` out balance_width: balance of the active account; 0 when no session.
- `wrong_psw` out 1: one-cycle pulse per rejected PIN.
- `pin_ok` out 1: level, high while authenticated.
- `invalid_card` out 1: one-cycle pulse; id out of range or account locked.
- `locked` out 1: one-cycle pulse when an account becomes locked.
- `session_active` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE
  - SELECT
  - WAIT_PIN
  - CHECK
  - AUTH
- Storage:
  - per-account PIN (constant, from package);
  - per-account balance register, reset to package initial value;
  - per-account lock bit, reset 0;
  - active id register;
  - 2-bit try counter;
  - latched PIN register.
- IDLE:
  - `card_in` latches `card_id` and goes to SELECT.
  - `pin_valid`, `commit` and `card_out` are ignored.
- SELECT (1 cycle):
  - If id ≥ NUM_ACCOUNTS or the lock bit is set: pulse `invalid_card`, go to IDLE.
  - Otherwise: load `current_balance` from the table, clear the try counter, go to WAIT_PIN.
- WAIT_PIN: `pin_valid` latches `pin` and goes to CHECK.
- CHECK (1 cycle):
  - PIN match: go to AUTH, raise `pin_ok`, clear tries.
  - Mismatch: pulse `wrong_psw` and increment tries.
    - If tries reaches MAX_TRIES: set the lock bit, pulse `locked`, go to IDLE.
    - Otherwise: go to WAIT_PIN.
- AUTH:
  - `commit` writes `balance_in` into the table and into `current_balance`, no arithmetic.
  - Widths are equal; no range check here, the FSM owns overdraft rules.
- `card_out` high in any non-IDLE state: go to IDLE next edge, clear `pin_ok`, zero `current_balance`.
- Priority, highest first:
  1. `card_out`
  2. `commit`
  3. `pin_valid`
- `commit` and `card_out` in the same AUTH cycle: the write is performed, then the block goes to IDLE.
- `card_in` outside IDLE is ignored.
- `commit` outside AUTH is ignored; the table is unchanged.
- Locks persist until `rst`.

## Timing
- Reset, asynchronous:
  - state IDLE;
  - all outputs 0;
  - balances reloaded from the package table;
  - lock bits cleared.
- `card_in` at edge N:
  - SELECT at N+1;
  - `current_balance` valid and state WAIT_PIN after N+2, or an `invalid_card` pulse during cycle N+2.
- `pin_valid` at edge N: CHECK result visible after N+2 (`pin_ok` high or `wrong_psw` pulse).
- `commit` at edge N: the table and `current_balance` show the new value after N+1.
- All outputs are registered; no combinational path from inputs.
- `rst` mid-session: session aborted, committed balances revert to initial values. A full reset is a power-on event by definition.

## Structure
- Shared package `atm_pkg`:
  - account-state localparams;
  - initial PIN and balance arrays for NUM_ACCOUNTS;
  - shared `balance_width` default.
- One sub-module, `pin_try_counter`: saturating try counter with clear/increment and a `limit_reached` flag.
- The table is plain register arrays; no RAM macro.

## Test plan
- Reset → all outputs 0; account 2 balance equals package value (e.g. 5000) on first select.
- `card_in`, id=2, correct PIN → `pin_ok`=1 after 2 cycles; `current_balance`=5000; `wrong_psw` never asserted.
- Authenticated on id 2, `commit` with `balance_in`=4200, then `card_out`, re-insert id 2 → `current_balance`=4200.
- Three wrong PINs on id 5 → three `wrong_psw` pulses, one `locked` pulse, IDLE. Re-insert id 5 → `invalid_card` pulse; a correct PIN is never checked.
- `card_in`, id=7 with NUM_ACCOUNTS=6 → `invalid_card` pulse, IDLE.
- `commit`+`card_out` same cycle → value written and state IDLE; `commit` in WAIT_PIN → table unchanged; `rst` mid-AUTH → outputs 0, balance back to initial.
